// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants for the EX/MEM pipeline register: reset instruction,
// zero word, and the layout of the opaque payload packed by the caller.
package ex_mem_pipe_pkg;

  // Canonical NOP (addi x0, x0, 0) shown on the output while in reset.
  localparam logic [31:0] NOP_INS   = 32'h00000013;
  localparam logic [31:0] ZERO_WORD = 32'h00000000;

  // Payload field layout (128-bit payload); the pipe treats it as opaque.
  localparam int unsigned PAY_RD_LSB  = 0;
  localparam int unsigned PAY_RD_W    = 5;
  localparam int unsigned PAY_UOP_LSB = 5;
  localparam int unsigned PAY_UOP_W   = 16;
  localparam int unsigned PAY_MEM_LSB = 21;
  localparam int unsigned PAY_MEM_W   = 40;
  localparam int unsigned PAY_CSR_LSB = 61;
  localparam int unsigned PAY_CSR_W   = 44;
  localparam int unsigned PAY_EXC_LSB = 105;
  localparam int unsigned PAY_EXC_W   = 23;

endpackage

// File: rtl/ex_mem_pipe_skid2.sv
// Two-entry elastic buffer: an output register plus a skid register.
// The ready output is registered and is low exactly when the skid entry
// is occupied, so the upstream path carries no combinational dependence
// on m_ready_i.
module pipe_skid2 #(
  parameter int unsigned   W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         s_ready_q, s_ready_d;
  logic         s_xfer_s;
  logic         out_free_s;

  assign s_xfer_s   = s_valid_i & s_ready_q;
  // Output slot can take new contents if empty or being drained this edge.
  assign out_free_s = ~out_valid_q | m_ready_i;

  // Next-state: flush empties both entries; skid drains into output first.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free_s) begin
      if (skid_valid_q) begin
        // Upstream was stalled (ready low), so no new beat competes here.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (s_xfer_s) begin
        out_valid_d = 1'b1;
        out_data_d  = s_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (s_xfer_s) begin
        skid_valid_d = 1'b1;
        skid_data_d  = s_data_i;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    s_ready_d = ~skid_valid_d;
  end

  // State registers; data fields hold across bubbles and flushes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= RST_VAL;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      s_ready_q    <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      s_ready_q    <= s_ready_d;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with branch-shadow PC attribution.
// Beats following a branch carry the branch PC until the first beat
// fetched from the branch target (slot end) has passed through.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int unsigned          PC_W    = 32,
  parameter int unsigned          INS_W   = 32,
  parameter int unsigned          PAY_W   = 128,
  parameter logic [INS_W-1:0]     NOP_INS = ex_mem_pipe_pkg::NOP_INS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [PC_W-1:0]  s_pc_i,
  input  logic [INS_W-1:0] s_ins_i,
  input  logic [PAY_W-1:0] s_pay_i,
  input  logic             s_br_tag_i,
  input  logic             s_slot_end_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [PC_W-1:0]  m_pc_o,
  output logic [INS_W-1:0] m_ins_o,
  output logic [PAY_W-1:0] m_pay_o
);

  localparam int unsigned     W      = PC_W + INS_W + PAY_W;
  localparam logic [PC_W-1:0] PC_RST = PC_W'(ZERO_WORD);
  localparam logic [W-1:0]    RST_VAL = {PC_RST, NOP_INS, {PAY_W{1'b0}}};

  logic            br_active_q, br_active_d;
  logic [PC_W-1:0] br_pc_q, br_pc_d;
  logic            s_ready_s;
  logic            s_xfer_s;
  logic [PC_W-1:0] attr_pc_s;
  logic [W-1:0]    s_data_s;
  logic [W-1:0]    m_data_s;

  assign s_xfer_s  = s_valid_i & s_ready_s;
  // Attribution uses the branch state as it was before this transfer.
  assign attr_pc_s = br_active_q ? br_pc_q : s_pc_i;
  assign s_data_s  = {attr_pc_s, s_ins_i, s_pay_i};

  // Branch attribution next-state: tag opens a shadow, slot end closes it.
  always_comb begin
    br_active_d = br_active_q;
    br_pc_d     = br_pc_q;
    if (flush_i) begin
      br_active_d = 1'b0;
    end else if (s_xfer_s) begin
      if (s_br_tag_i) begin
        br_active_d = 1'b1;
        br_pc_d     = s_pc_i;
      end else if (s_slot_end_i && br_active_q) begin
        br_active_d = 1'b0;
      end else begin
        br_active_d = br_active_q;
      end
    end else begin
      br_active_d = br_active_q;
    end
  end

  // Branch attribution state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_active_q <= 1'b0;
      br_pc_q     <= PC_RST;
    end else begin
      br_active_q <= br_active_d;
      br_pc_q     <= br_pc_d;
    end
  end

  pipe_skid2 #(
    .W       (W),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_s),
    .s_data_i  (s_data_s),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_s)
  );

  assign s_ready_o = s_ready_s;
  assign m_pc_o    = m_data_s[W-1 -: PC_W];
  assign m_ins_o   = m_data_s[PAY_W +: INS_W];
  assign m_pay_o   = m_data_s[PAY_W-1:0];

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe.
module tb_ex_mem_pipe;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         s_valid_i = 1'b0;
  logic         s_ready_o;
  logic [31:0]  s_pc_i = 32'h0;
  logic [31:0]  s_ins_i = 32'h0;
  logic [127:0] s_pay_i = 128'h0;
  logic         s_br_tag_i = 1'b0;
  logic         s_slot_end_i = 1'b0;
  logic         m_valid_o;
  logic         m_ready_i = 1'b0;
  logic [31:0]  m_pc_o;
  logic [31:0]  m_ins_o;
  logic [127:0] m_pay_o;

  int tests_run = 0;
  int tests_failed = 0;

  ex_mem_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_pc_i(s_pc_i), .s_ins_i(s_ins_i), .s_pay_i(s_pay_i),
    .s_br_tag_i(s_br_tag_i), .s_slot_end_i(s_slot_end_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_pc_o(m_pc_o), .m_ins_o(m_ins_o), .m_pay_o(m_pay_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hABCD0000;
  endfunction

  function automatic logic [127:0] pay_of(input logic [31:0] pc);
    return {pc, ~pc, pc + 32'd1, 32'h5A5A0000 | pc};
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic tag, input logic se);
    s_valid_i    = v;
    s_pc_i       = pc;
    s_ins_i      = ins_of(pc);
    s_pay_i      = pay_of(pc);
    s_br_tag_i   = tag;
    s_slot_end_i = se;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    tests_run++; if (m_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mvalid got %b exp 0", m_valid_o); end
    tests_run++; if (s_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_sready got %b exp 1", s_ready_o); end
    tests_run++; if (m_pc_o !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h exp 0", m_pc_o); end
    tests_run++; if (m_ins_o !== 32'h00000013) begin tests_failed++; $display("FAIL reset_ins got %h exp 00000013", m_ins_o); end
    tests_run++; if (m_pay_o !== 128'h0) begin tests_failed++; $display("FAIL reset_pay got %h exp 0", m_pay_o); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    m_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, pcs[i], 1'b0, 1'b0);
      step();
      tests_run++; if (m_valid_o !== 1'b1 || m_pc_o !== pcs[i]) begin tests_failed++; $display("FAIL stream_beat%0d got v=%b pc=%h exp v=1 pc=%h", i, m_valid_o, m_pc_o, pcs[i]); end
      tests_run++; if (m_ins_o !== ins_of(pcs[i]) || m_pay_o !== pay_of(pcs[i])) begin tests_failed++; $display("FAIL stream_data%0d got ins=%h exp %h", i, m_ins_o, ins_of(pcs[i])); end
    end
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    tests_run++; if (m_valid_o !== 1'b0) begin tests_failed++; $display("FAIL stream_bubble got v=%b exp 0", m_valid_o); end
    tests_run++; if (m_pc_o !== 32'h108 || m_ins_o !== ins_of(32'h108)) begin tests_failed++; $display("FAIL bubble_hold got pc=%h exp 108", m_pc_o); end
  endtask

  task automatic test_backpressure();
    m_ready_i = 1'b0;
    offer(1'b1, 32'h500, 1'b0, 1'b0);
    step();
    tests_run++; if (m_valid_o !== 1'b1 || m_pc_o !== 32'h500 || s_ready_o !== 1'b1) begin tests_failed++; $display("FAIL bp_first got v=%b pc=%h rdy=%b exp 1 500 1", m_valid_o, m_pc_o, s_ready_o); end
    offer(1'b1, 32'h504, 1'b0, 1'b0);
    step();
    tests_run++; if (s_ready_o !== 1'b0 || m_pc_o !== 32'h500) begin tests_failed++; $display("FAIL bp_second got rdy=%b pc=%h exp 0 500", s_ready_o, m_pc_o); end
    offer(1'b1, 32'h508, 1'b0, 1'b0);
    step();
    tests_run++; if (s_ready_o !== 1'b0 || m_valid_o !== 1'b1) begin tests_failed++; $display("FAIL bp_third got rdy=%b v=%b exp 0 1", s_ready_o, m_valid_o); end
    tests_run++; if (m_pc_o !== 32'h500 || m_ins_o !== ins_of(32'h500) || m_pay_o !== pay_of(32'h500)) begin tests_failed++; $display("FAIL bp_stable got pc=%h exp 500", m_pc_o); end
    m_ready_i = 1'b1;
    step();
    tests_run++; if (m_valid_o !== 1'b1 || m_pc_o !== 32'h504 || s_ready_o !== 1'b1) begin tests_failed++; $display("FAIL bp_release1 got v=%b pc=%h rdy=%b exp 1 504 1", m_valid_o, m_pc_o, s_ready_o); end
    step();
    tests_run++; if (m_valid_o !== 1'b1 || m_pc_o !== 32'h508) begin tests_failed++; $display("FAIL bp_release2 got v=%b pc=%h exp 1 508", m_valid_o, m_pc_o); end
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    tests_run++; if (m_valid_o !== 1'b0) begin tests_failed++; $display("FAIL bp_drain got v=%b exp 0", m_valid_o); end
  endtask

  task automatic test_branch();
    logic [31:0] in_pc [4];
    logic        in_tag [4];
    logic        in_se [4];
    logic [31:0] exp_pc [4];
    in_pc[0] = 32'h200; in_tag[0] = 1'b1; in_se[0] = 1'b0; exp_pc[0] = 32'h200;
    in_pc[1] = 32'h204; in_tag[1] = 1'b0; in_se[1] = 1'b0; exp_pc[1] = 32'h200;
    in_pc[2] = 32'h300; in_tag[2] = 1'b0; in_se[2] = 1'b1; exp_pc[2] = 32'h200;
    in_pc[3] = 32'h304; in_tag[3] = 1'b0; in_se[3] = 1'b0; exp_pc[3] = 32'h304;
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, in_pc[i], in_tag[i], in_se[i]);
      step();
      tests_run++; if (m_valid_o !== 1'b1 || m_pc_o !== exp_pc[i] || m_ins_o !== ins_of(in_pc[i])) begin tests_failed++; $display("FAIL branch_beat%0d got v=%b pc=%h ins=%h exp pc=%h ins=%h", i, m_valid_o, m_pc_o, m_ins_o, exp_pc[i], ins_of(in_pc[i])); end
    end
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_self_loop();
    logic [31:0] in_pc [6];
    logic        in_tag [6];
    logic        in_se [6];
    logic [31:0] exp_pc [6];
    in_pc[0] = 32'h400; in_tag[0] = 1'b1; in_se[0] = 1'b1; exp_pc[0] = 32'h400;
    in_pc[1] = 32'h404; in_tag[1] = 1'b0; in_se[1] = 1'b0; exp_pc[1] = 32'h400;
    in_pc[2] = 32'h408; in_tag[2] = 1'b0; in_se[2] = 1'b1; exp_pc[2] = 32'h400;
    in_pc[3] = 32'h40C; in_tag[3] = 1'b0; in_se[3] = 1'b0; exp_pc[3] = 32'h40C;
    in_pc[4] = 32'h410; in_tag[4] = 1'b0; in_se[4] = 1'b1; exp_pc[4] = 32'h410;
    in_pc[5] = 32'h414; in_tag[5] = 1'b0; in_se[5] = 1'b0; exp_pc[5] = 32'h414;
    m_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      offer(1'b1, in_pc[i], in_tag[i], in_se[i]);
      step();
      tests_run++; if (m_valid_o !== 1'b1 || m_pc_o !== exp_pc[i]) begin tests_failed++; $display("FAIL selfloop_beat%0d got v=%b pc=%h exp pc=%h", i, m_valid_o, m_pc_o, exp_pc[i]); end
    end
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_flush();
    m_ready_i = 1'b0;
    offer(1'b1, 32'h600, 1'b1, 1'b0);
    step();
    offer(1'b1, 32'h604, 1'b0, 1'b0);
    step();
    tests_run++; if (s_ready_o !== 1'b0 || m_pc_o !== 32'h600) begin tests_failed++; $display("FAIL flush_full got rdy=%b pc=%h exp 0 600", s_ready_o, m_pc_o); end
    offer(1'b1, 32'h608, 1'b0, 1'b0);
    flush_i = 1'b1;
    m_ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    tests_run++; if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin tests_failed++; $display("FAIL flush_empty got v=%b rdy=%b exp 0 1", m_valid_o, s_ready_o); end
    offer(1'b1, 32'h60C, 1'b0, 1'b0);
    step();
    tests_run++; if (m_valid_o !== 1'b1 || m_pc_o !== 32'h60C) begin tests_failed++; $display("FAIL flush_br_clear got v=%b pc=%h exp 1 60c", m_valid_o, m_pc_o); end
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    tests_run++; if (m_valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_nodup got v=%b exp 0", m_valid_o); end
  endtask

  task automatic test_reset_mid();
    m_ready_i = 1'b0;
    offer(1'b1, 32'h700, 1'b1, 1'b0);
    step();
    offer(1'b1, 32'h704, 1'b0, 1'b0);
    step();
    offer(1'b1, 32'h708, 1'b0, 1'b0);
    rst_i = 1'b1;
    flush_i = 1'b1;
    step();
    rst_i = 1'b0;
    flush_i = 1'b0;
    tests_run++; if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ctrl got v=%b rdy=%b exp 0 1", m_valid_o, s_ready_o); end
    tests_run++; if (m_pc_o !== 32'h0 || m_ins_o !== 32'h00000013 || m_pay_o !== 128'h0) begin tests_failed++; $display("FAIL rstmid_data got pc=%h ins=%h exp 0 00000013", m_pc_o, m_ins_o); end
    m_ready_i = 1'b1;
    offer(1'b1, 32'h70C, 1'b0, 1'b0);
    step();
    tests_run++; if (m_valid_o !== 1'b1 || m_pc_o !== 32'h70C) begin tests_failed++; $display("FAIL rstmid_br_clear got v=%b pc=%h exp 1 70c", m_valid_o, m_pc_o); end
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    tests_run++; if (m_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_nodup got v=%b exp 0", m_valid_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_self_loop();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter PC_W, 32, PC width.
REQ-003 Parameter INS_W, 32, instruction width.
REQ-004 Parameter PAY_W, 128, opaque payload width (rd/uop/mem/csr/exception fields packed by the caller).
REQ-005 Parameter NOP_INS, 32'h00000013, instruction value presented in reset state.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 flush_i  in  1  discard all held and in-flight beats.
REQ-009 s_valid_i  in  1  upstream beat valid.
REQ-010 s_ready_o  out  1  block can accept a beat.
REQ-011 s_pc_i  in  PC_W  beat PC.
REQ-012 s_ins_i  in  INS_W  beat instruction.
REQ-013 s_pay_i  in  PAY_W  beat payload.
REQ-014 s_br_tag_i  in  1  beat is a branch instruction.
REQ-015 s_slot_end_i  in  1  beat is the first fetched from the branch target.
REQ-016 m_valid_o  out  1  downstream beat valid.
REQ-017 m_ready_i  in  1  downstream accepts.
REQ-018 m_pc_o  out  PC_W  attributed PC.
REQ-019 m_ins_o  out  INS_W  instruction.
REQ-020 m_pay_o  out  PAY_W  payload.

Function
REQ-021 Upstream transfer SHALL occur when s_valid_i && s_ready_o; downstream transfer when m_valid_o && m_ready_i.
REQ-022 Storage SHALL be two entries (output reg + skid reg); s_ready_o SHALL be registered and equal !skid_valid.
REQ-023 Latency SHALL be 1 cycle from upstream transfer to m_valid_o when the block is empty; throughput SHALL be 1 beat/cycle while m_ready_i=1.
REQ-024 Beats SHALL leave in arrival order; none dropped or duplicated except by flush/reset.
REQ-025 When m_ready_i=0 with output valid, an accepted beat SHALL enter the skid reg; when the output reg drains, skid contents SHALL move to it the same edge.
REQ-026 m_pc_o/m_ins_o/m_pay_o SHALL be stable while m_valid_o=1 and m_ready_i=0.
REQ-027 Branch attribution state br_active (1 bit) and br_pc (PC_W) SHALL update only on upstream transfer.
REQ-028 On transfer, stored PC SHALL be br_pc if br_active (pre-update) else s_pc_i.
REQ-029 On transfer with s_br_tag_i=1: br_active<=1, br_pc<=s_pc_i, regardless of s_slot_end_i (tag wins).
REQ-030 On transfer with s_br_tag_i=0, s_slot_end_i=1, br_active=1: br_active<=0.
REQ-031 s_slot_end_i with br_active=0 SHALL be ignored.
REQ-032 flush_i=1 SHALL clear both entry valids and br_active at the edge; a beat offered that cycle SHALL be discarded; s_ready_o=1 next cycle.
REQ-033 flush_i SHALL take priority over all transfers in the same cycle.
REQ-034 Data fields SHALL hold last value when m_valid_o=0 (no zeroing on bubble).

Reset
REQ-035 rst_i SHALL set m_valid_o=0, skid_valid=0, s_ready_o=1, m_pc_o=0, m_ins_o=NOP_INS, m_pay_o=0, br_active=0, br_pc=0.
REQ-036 Reset asserted mid-operation SHALL discard all held beats, including a beat offered that cycle; rst_i has priority over flush_i.

Structure
REQ-037 NOP_INS, ZERO_WORD and the payload field layout SHALL live in the shared defines package.
REQ-038 The two-entry storage SHALL be one sub-module pipe_skid2 (params W); branch attribution SHALL stay in ex_mem_pipe.

Verification
REQ-039 Stream pc 0x100,0x104,0x108 with m_ready_i=1 -> same pcs out, each 1 cycle later, no bubbles.
REQ-040 m_ready_i=0 for 3 cycles while streaming -> 2 beats held, s_ready_o=0 on 3rd, release yields order preserved.
REQ-041 Branch at pc 0x200 (tag), then 0x204, then 0x300 (slot_end) -> m_pc_o 0x200,0x200,0x200, next beat own pc.
REQ-042 Beat with tag=1 and slot_end=1 at 0x400 (self-loop) -> br_active stays 1, br_pc=0x400.
REQ-043 flush_i with both entries full and a beat offered -> m_valid_o=0 next cycle, s_ready_o=1, br_active=0.
REQ-044 rst_i mid-stream -> all outputs at REQ-035 values next cycle.
